arb5_ctrl: RTL and testbench

- Round-robin arbiter and sequencer for a shared 5-input resource such as the memory-bus port, whose 5-way select mux uses the encoding 000..100.
- Accepts up to five requesters and grants exactly one at a time.
- Holds each grant until the owner signals transaction completion.
- Drives the matching encoded mux select alongside the one-hot grant.

---
 rtl/arb5_ctrl.sv | 119 +++++++++++
 tb/tb_arb5_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/arb5_ctrl.sv
// Round-robin arbiter for a shared 5-input resource: one-hot grant plus encoded mux select.
// Optional forced release after TIMEOUT held cycles when ARB_TIMEOUT_EN is defined.
module arb5_ctrl #(
   parameter int TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] req,
   input  logic       done,
   output logic [4:0] grant,
   output logic [2:0] sel,
   output logic       busy,
   output logic       timeout_err
);

   typedef enum logic {IDLE, OWNED} state_t;

   state_t     state_q, state_d;
   logic [2:0] last_q, last_d;
   logic [4:0] grant_q, grant_d;
   logic [2:0] sel_q, sel_d;
   logic       busy_q, busy_d;
   logic       terr_q, terr_d;

   logic [2:0] start;
   logic [2:0] win;
   logic       found;
   logic       tmo;
   logic       rel;
   logic       new_grant;

   // Search begins just after the previous winner, so the departing owner ranks last.
   always_comb begin
      start = (last_q == 3'd4) ? 3'd0 : last_q + 3'd1;
      win   = 3'd0;
      found = 1'b0;
      for (int i = 0; i < 5; i++) begin
         int idx;
         idx = int'(start) + i;
         if (idx > 4) idx = idx - 5;
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = 3'(idx);
         end
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt_q, cnt_d;

   assign tmo = (state_q == OWNED) && !done && (cnt_q == CW'(TIMEOUT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (new_grant || rel)
         cnt_d = '0;
      else if (state_q == OWNED && !done && cnt_q != '1)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
`else
   assign tmo = 1'b0;
`endif

   assign rel       = (state_q == OWNED) && (done || tmo);
   assign new_grant = found && ((state_q == IDLE) || rel);

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      grant_d = grant_q;
      sel_d   = sel_q;
      busy_d  = busy_q;
      terr_d  = tmo;
      if (state_q == IDLE || rel) begin
         if (found) begin
            state_d = OWNED;
            last_d  = win;
            grant_d = 5'd1 << win;
            sel_d   = win;
            busy_d  = 1'b1;
         end else begin
            state_d = IDLE;
            grant_d = 5'd0;
            sel_d   = 3'd0;
            busy_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= 3'd4;
         grant_q <= 5'd0;
         sel_q   <= 3'd0;
         busy_q  <= 1'b0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         sel_q   <= sel_d;
         busy_q  <= busy_d;
         terr_q  <= terr_d;
      end
   end

   assign grant       = grant_q;
   assign sel         = sel_q;
   assign busy        = busy_q;
   assign timeout_err = terr_q;

endmodule

// File: tb/tb_arb5_ctrl.sv
// Randomised and directed bench for arb5_ctrl against a round-robin reference model.
module tb_arb5_ctrl;

`ifdef ARB_TIMEOUT_EN
   localparam int TMO    = 4;
   localparam bit TMO_EN = 1'b1;
`else
   localparam int TMO    = 255;
   localparam bit TMO_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [4:0] req = 5'd0;
   logic       done = 1'b0;
   logic [4:0] grant;
   logic [2:0] sel;
   logic       busy;
   logic       timeout_err;

   int checks   = 0;
   int failures = 0;

   // Reference model: owner index (-1 when idle), last winner, owned cycles so far.
   int m_owner = -1;
   int m_last  = 4;
   int m_held  = 0;
   bit m_terr  = 1'b0;

   arb5_ctrl #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .req(req), .done(done),
      .grant(grant), .sel(sel), .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   function automatic int m_pick(logic [4:0] r, int after);
      for (int k = 1; k <= 5; k++) begin
         int j;
         j = (after + k) % 5;
         if (r[j]) return j;
      end
      return -1;
   endfunction

   function automatic logic [9:0] exp_vec();
      logic [4:0] g;
      logic [2:0] s;
      g = (m_owner < 0) ? 5'd0 : (5'd1 << m_owner);
      s = (m_owner < 0) ? 3'd0 : 3'(m_owner);
      return {g, s, (m_owner >= 0), m_terr};
   endfunction

   task automatic model_edge();
      int w;
      bit to;
      if (rst) begin
         m_owner = -1; m_last = 4; m_held = 0; m_terr = 1'b0;
      end else if (m_owner < 0) begin
         m_terr = 1'b0;
         w = m_pick(req, m_last);
         if (w >= 0) begin m_owner = w; m_last = w; m_held = 1; end
      end else begin
         to = TMO_EN && !done && (m_held == TMO);
         m_terr = to;
         if (done || to) begin
            w = m_pick(req, m_owner);
            if (w >= 0) begin m_owner = w; m_last = w; m_held = 1; end
            else begin m_owner = -1; m_held = 0; end
         end else begin
            m_held++;
         end
      end
   endtask

   task automatic tick(input logic [4:0] r, input logic d, input logic rs);
      req = r; done = d; rst = rs;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      tick(5'd0, 1'b0, 1'b1);
      checks++;
      if ({grant, sel, busy, timeout_err} !== 10'd0) begin
         failures++;
         $display("FAIL reset_outputs got=%b exp=%b", {grant, sel, busy, timeout_err}, 10'd0);
      end
      tick(5'd0, 1'b0, 1'b0);
      checks++;
      if ({grant, sel, busy, timeout_err} !== exp_vec()) begin
         failures++;
         $display("FAIL reset_idle got=%b exp=%b", {grant, sel, busy, timeout_err}, exp_vec());
      end
   endtask

   task automatic test_single();
      tick(5'b00100, 1'b0, 1'b0);
      checks++;
      if ({grant, sel, busy} !== {5'b00100, 3'b010, 1'b1}) begin
         failures++;
         $display("FAIL single_grant got=%b/%b/%b exp=00100/010/1", grant, sel, busy);
      end
      tick(5'b00000, 1'b1, 1'b0);
      checks++;
      if ({grant, sel, busy} !== 9'd0) begin
         failures++;
         $display("FAIL single_release got=%b/%b/%b exp=00000/000/0", grant, sel, busy);
      end
   endtask

   task automatic test_priority();
      logic [2:0] order [6];
      order = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
      tick(5'd0, 1'b0, 1'b1);
      tick(5'b11111, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (grant !== (5'd1 << order[i]) || sel !== order[i] || busy !== 1'b1) begin
            failures++;
            $display("FAIL priority_%0d got=%b/%b exp_sel=%b", i, grant, sel, order[i]);
         end
         tick(5'b11111, 1'b1, 1'b0);
      end
      tick(5'd0, 1'b1, 1'b0);
   endtask

   task automatic test_wrap();
      tick(5'd0, 1'b0, 1'b1);
      tick(5'b01000, 1'b0, 1'b0);
      tick(5'b00000, 1'b1, 1'b0);
      tick(5'b01001, 1'b0, 1'b0);
      checks++;
      if (grant !== 5'b00001 || sel !== 3'b000) begin
         failures++;
         $display("FAIL wrap_last3 got=%b/%b exp=00001/000", grant, sel);
      end
      tick(5'b10000, 1'b1, 1'b0);
      tick(5'b00000, 1'b1, 1'b0);
      tick(5'b10000, 1'b0, 1'b0);
      checks++;
      if (grant !== 5'b10000 || sel !== 3'b100) begin
         failures++;
         $display("FAIL wrap_last4 got=%b/%b exp=10000/100", grant, sel);
      end
      tick(5'd0, 1'b1, 1'b0);
   endtask

   task automatic test_hold();
      tick(5'd0, 1'b0, 1'b1);
      tick(5'b00010, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         tick(5'b00000, 1'b0, 1'b0);
         checks++;
         if ({grant, sel, busy, timeout_err} !== exp_vec()) begin
            failures++;
            $display("FAIL hold_%0d got=%b exp=%b", i, {grant, sel, busy, timeout_err}, exp_vec());
         end
      end
      tick(5'd0, 1'b1, 1'b0);
      tick(5'd0, 1'b1, 1'b0);
      tick(5'd0, 1'b1, 1'b0);
      checks++;
      if ({grant, sel, busy, timeout_err} !== exp_vec() || busy !== 1'b0) begin
         failures++;
         $display("FAIL idle_done got=%b exp=%b", {grant, sel, busy, timeout_err}, exp_vec());
      end
   endtask

   task automatic test_reset_mid();
      tick(5'd0, 1'b0, 1'b1);
      tick(5'b01000, 1'b0, 1'b0);
      tick(5'b11111, 1'b0, 1'b1);
      checks++;
      if (grant !== 5'd0 || sel !== 3'd0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid got=%b/%b/%b exp=00000/000/0", grant, sel, busy);
      end
      tick(5'b11111, 1'b0, 1'b0);
      checks++;
      if (grant !== 5'b00001 || sel !== 3'b000) begin
         failures++;
         $display("FAIL reset_mid_first got=%b/%b exp=00001/000", grant, sel);
      end
      tick(5'd0, 1'b1, 1'b0);
   endtask

   task automatic test_timeout();
      int pulses;
      pulses = 0;
      tick(5'd0, 1'b0, 1'b1);
      tick(5'b00100, 1'b0, 1'b0);
      for (int i = 0; i < 120; i++) begin
         tick((i >= 2) ? 5'b01000 : 5'b00100, 1'b0, 1'b0);
         if (timeout_err) pulses++;
         checks++;
         if ({grant, sel, busy, timeout_err} !== exp_vec()) begin
            failures++;
            $display("FAIL timeout_%0d got=%b exp=%b", i, {grant, sel, busy, timeout_err}, exp_vec());
         end
      end
      checks++;
      if (TMO_EN ? (pulses == 0) : (pulses != 0 || grant !== 5'b00100)) begin
         failures++;
         $display("FAIL timeout_summary pulses=%0d grant=%b", pulses, grant);
      end
      tick(5'd0, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      logic [4:0] r;
      logic d, rs;
      tick(5'd0, 1'b0, 1'b1);
      for (int i = 0; i < 600; i++) begin
         r  = 5'($urandom);
         d  = ($urandom_range(0, 3) == 0);
         rs = ($urandom_range(0, 63) == 0);
         tick(r, d, rs);
         checks++;
         if ({grant, sel, busy, timeout_err} !== exp_vec()) begin
            failures++;
            $display("FAIL random_%0d got=%b exp=%b", i, {grant, sel, busy, timeout_err}, exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_priority();
      test_wrap();
      test_hold();
      test_reset_mid();
      test_timeout();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
